fp32_add_arbiter: RTL and testbench

Round-robin scheduler that shares one `adder_fp32` instance among `NUM_REQ` requesters inside the co-processor. Each requester presents two fp32 operands and an add/subtract flag with a STB/BUSY handshake. The arbiter latches one request, issues it to the adder, collects the sum and returns it to the originating requester. Only one operation is in flight at a time.

---
 rtl/fp_arb_pkg.sv | 23 ++
 rtl/fp32_add_arbiter_rr_pick.sv | 47 ++++
 rtl/fp32_add_arbiter.sv | 154 +++++++++++++++
 tb/tb_fp32_add_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// -----------------------------------------------------------------------------
// fp_arb_pkg
//   Shared definitions for the fp32 adder arbiter: FSM state encoding and
//   fp32 field constants.
// -----------------------------------------------------------------------------
package fp_arb_pkg;

  localparam int FP32_W      = 32;
  localparam int FP_SIGN_BIT = 31;

  // Arbiter sequencing:
  //   IDLE  - pick a requester and latch its operands
  //   ISSUE - present operands to the adder until it accepts
  //   WAIT  - wait for the adder result
  //   RESP  - hold the result for the originating requester
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage : fp_arb_pkg

// File: rtl/fp32_add_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Starting at ptr and moving upward
//   (mod NUM_REQ), returns the index of the first set req bit.
//
//   Ports:
//     req  in  NUM_REQ  request bits
//     ptr  in  PTR_W    highest-priority index for this pick
//     gnt  out PTR_W    selected index (0 when nothing is requested)
//     any  out 1        at least one req bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   gnt,
  output logic               any
);

  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] idx;

  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gnt  = '0;
    any  = 1'b0;
    cand = '0;
    idx  = '0;
    // Walk from the farthest candidate back to ptr so the closest set bit
    // (lowest offset from ptr) is the last one written and therefore wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      idx = cand[PTR_W-1:0];
      if (req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fp32_add_arbiter.sv
// -----------------------------------------------------------------------------
// fp32_add_arbiter
//   Round-robin scheduler sharing one fp32 adder among NUM_REQ requesters.
//   One operation is in flight at a time: a request is latched, issued to the
//   adder, the sum captured, and returned to the originating requester.
//   Subtraction is done by flipping the sign bit of b before issue. The
//   adder sits beside this block at the top level with its rst tied to
//   ~resetn so both reset together.
//
//   Ports:
//     clk              in   clock
//     resetn           in   synchronous active-low reset
//     req_stb          in   [NUM_REQ]       request valid per requester
//     req_a, req_b     in   [NUM_REQ*FP_W]  packed operands, slice i at i*FP_W
//     req_sub          in   [NUM_REQ]       1 = a - b
//     req_busy         out  [NUM_REQ]       0 only for the requester granted now
//     rsp_stb          out  [NUM_REQ]       one-hot result valid
//     rsp_sum          out  [FP_W]          shared result bus
//     rsp_busy         in   [NUM_REQ]       requester cannot take its result
//     add_a, add_b     out  [FP_W]          adder operands
//     add_input_stb    out  adder input strobe
//     add_busy         in   adder input BUSY
//     add_sum          in   [FP_W]          adder result
//     add_output_stb   in   adder output strobe
//     add_output_busy  out  drives the adder's output BUSY
// -----------------------------------------------------------------------------
module fp32_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FP_W    = FP32_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_stb,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [NUM_REQ-1:0]      req_busy,
  output logic [NUM_REQ-1:0]      rsp_stb,
  output logic [FP_W-1:0]         rsp_sum,
  input  logic [NUM_REQ-1:0]      rsp_busy,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  output logic                    add_input_stb,
  input  logic                    add_busy,
  input  logic [FP_W-1:0]         add_sum,
  input  logic                    add_output_stb,
  output logic                    add_output_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e       state, state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt;
  logic [PTR_W-1:0] gnt_q;
  logic             any_req;
  logic             accept;
  logic [FP_W-1:0]  a_q, b_q, sum_q;

  // Unpacked views of the operand buses, indexed by requester.
  logic [FP_W-1:0]  a_arr [NUM_REQ];
  logic [FP_W-1:0]  b_arr [NUM_REQ];
  logic [FP_W-1:0]  b_eff;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*FP_W +: FP_W];
      b_arr[i] = req_b[i*FP_W +: FP_W];
    end
  end

  // a - b is issued as a + (-b): flip only the sign bit, so NaN and zero
  // operands are treated the same as any other value.
  assign b_eff = b_arr[gnt] ^ (FP_W'(req_sub[gnt]) << FP_SIGN_BIT);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (req_stb),
    .ptr (ptr),
    .gnt (gnt),
    .any (any_req)
  );

  // Next-state and handshake decode. req_busy is the only combinational
  // output; no grant is offered while resetn is low.
  always_comb begin
    state_next = state;
    req_busy   = '1;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (resetn && any_req) begin
          req_busy[gnt] = 1'b0;
          accept        = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (!add_busy) state_next = WAIT;
      end
      WAIT: begin
        if (add_output_stb) state_next = RESP;
      end
      RESP: begin
        if (!rsp_busy[gnt_q]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= '0;
      gnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q   <= a_arr[gnt];
        b_q   <= b_eff;
        gnt_q <= gnt;
      end
      if (state == WAIT && add_output_stb) begin
        sum_q <= add_sum;
      end
      // Priority moves to the requester after the one just served.
      if (state == RESP && !rsp_busy[gnt_q]) begin
        ptr <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
      end
    end
  end

  // Registered-state output decode.
  assign add_a           = a_q;
  assign add_b           = b_q;
  assign add_input_stb   = (state == ISSUE);
  assign add_output_busy = (state != WAIT);
  assign rsp_sum         = sum_q;

  always_comb begin
    rsp_stb        = '0;
    rsp_stb[gnt_q] = (state == RESP);
  end

endmodule : fp32_add_arbiter

// File: tb/tb_fp32_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp32_add_arbiter
//   Scoreboard bench for fp32_add_arbiter. A small adder model returns sums
//   for a fixed set of operand pairs (unknown pairs give 0xDEADBEEF). Tests
//   push the expected (requester, sum) pairs in service order; a monitor pops
//   and compares each completed response.
// -----------------------------------------------------------------------------
module tb_fp32_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_stb, req_sub, rsp_busy;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_busy, rsp_stb;
  logic [W-1:0]   rsp_sum, add_a, add_b, add_sum;
  logic           add_input_stb, add_busy, add_output_stb, add_output_busy;

  always #5 clk = ~clk;

  fp32_add_arbiter #(.NUM_REQ(N), .FP_W(W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_stb         (req_stb),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_sub         (req_sub),
    .req_busy        (req_busy),
    .rsp_stb         (rsp_stb),
    .rsp_sum         (rsp_sum),
    .rsp_busy        (rsp_busy),
    .add_a           (add_a),
    .add_b           (add_b),
    .add_input_stb   (add_input_stb),
    .add_busy        (add_busy),
    .add_sum         (add_sum),
    .add_output_stb  (add_output_stb),
    .add_output_busy (add_output_busy)
  );

  // ---------------- adder model ----------------
  typedef enum logic [1:0] {M_IDLE, M_CALC, M_OUT, M_GET} m_state_e;
  m_state_e     m_state;
  logic [1:0]   m_cnt;
  logic [W-1:0] m_res;
  wire          add_rst = ~resetn;

  function automatic logic [W-1:0] lookup(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;  // 1 + 2
      {32'h40400000, 32'hBF800000}: return 32'h40000000;  // 3 + -1
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;  // 1 + 1
      {32'h40000000, 32'h40000000}: return 32'h40800000;  // 2 + 2
      {32'h7F800000, 32'hFF800000}: return 32'hFFC00000;  // inf + -inf
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (add_rst) begin
      m_state <= M_IDLE;
      m_cnt   <= '0;
      m_res   <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (add_input_stb) begin
          m_res   <= lookup(add_a, add_b);
          m_cnt   <= 2'd2;
          m_state <= M_CALC;
        end
        M_CALC: if (m_cnt == 0) m_state <= M_OUT; else m_cnt <= m_cnt - 2'd1;
        M_OUT:  if (!add_output_busy) m_state <= M_GET;
        M_GET:  m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  assign add_busy       = (m_state != M_IDLE);
  assign add_output_stb = (m_state == M_OUT);
  assign add_sum        = m_res;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] sum;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic expect_rsp(input int idx, input logic [W-1:0] sum);
    exp_t e;
    e.idx = idx;
    e.sum = sum;
    sb.push_back(e);
  endtask

  // A response completes on the next posedge when its requester is not busy.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (rsp_stb & ~rsp_busy) != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_stb), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_stb", 32'(rsp_stb), 32'(1) << mon_e.idx);
        check("rsp_sum", rsp_sum, mon_e.sum);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_sub[idx]      = sub;
  endtask

  // Raise the masked strobes and hold each until its grant is taken.
  task automatic send(input logic [N-1:0] mask);
    logic [N-1:0] acc;
    int cyc = 0;
    req_stb = req_stb | mask;
    while ((req_stb & mask) != '0 && cyc < 200) begin
      @(negedge clk);
      acc = req_stb & ~req_busy;
      @(posedge clk);
      #1;
      req_stb = req_stb & ~acc;
      cyc++;
    end
    check("send_accepted", 32'(req_stb & mask), 32'h0);
    req_stb = req_stb & ~mask;
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_empty", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    resetn   = 1'b0;
    req_stb  = '0;
    req_sub  = '0;
    rsp_busy = '0;
    req_a    = '0;
    req_b    = '0;

    // All four requesters present 1 + 1 while reset is held.
    for (int i = 0; i < N; i++) set_op(i, 32'h3F800000, 32'h3F800000, 1'b0);
    req_stb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_add_input_stb",   32'(add_input_stb),   32'h0);
    check("rst_add_output_busy", 32'(add_output_busy), 32'h1);
    check("rst_rsp_stb",         32'(rsp_stb),         32'h0);
    check("rst_rsp_sum",         rsp_sum,              32'h0);
    check("rst_req_busy",        32'(req_busy),        32'hF);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Simultaneous requests after reset: served 0,1,2,3.
    for (int i = 0; i < N; i++) expect_rsp(i, 32'h40000000);
    send(4'hF);
    drain();

    // Again: pointer wrapped to 0, so same order.
    for (int i = 0; i < N; i++) expect_rsp(i, 32'h40000000);
    send(4'hF);
    drain();

    // Requester 0 alone: 1 + 2 = 3.
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    expect_rsp(0, 32'h40400000);
    send(4'b0001);
    drain();

    // Requester 1: 3 - 1 = 2.
    set_op(1, 32'h40400000, 32'h3F800000, 1'b1);
    expect_rsp(1, 32'h40000000);
    send(4'b0010);
    drain();

    // Requester 3: inf - inf = NaN (0xFFC00000).
    set_op(3, 32'h7F800000, 32'h7F800000, 1'b1);
    expect_rsp(3, 32'hFFC00000);
    send(4'b1000);
    drain();

    // Requester 2 stalls its response for 5 cycles; requester 0 waits meanwhile.
    rsp_busy[2] = 1'b1;
    set_op(2, 32'h40000000, 32'h40000000, 1'b0);
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    expect_rsp(2, 32'h40800000);
    expect_rsp(0, 32'h40400000);
    send(4'b0100);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rsp_stb[2] !== 1'b1 && cyc < 50);
    check("stall_reach_resp", 32'(rsp_stb), 32'h4);
    req_stb[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_stb",       32'(rsp_stb),       32'h4);
      check("stall_rsp_sum",       rsp_sum,            32'h40800000);
      check("stall_add_input_stb", 32'(add_input_stb), 32'h0);
      check("stall_req_busy",      32'(req_busy),      32'hF);
    end
    @(posedge clk);
    #1;
    rsp_busy[2] = 1'b0;
    send(4'b0001);
    drain();

    // Reset in WAIT: in-flight result discarded, pointer returns to 0.
    set_op(1, 32'h40400000, 32'h3F800000, 1'b1);
    send(4'b0010);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (add_output_busy !== 1'b0 && cyc < 50);
    check("reach_wait", 32'(add_output_busy), 32'h0);
    resetn = 1'b0;
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(1, 32'h3F800000, 32'h40000000, 1'b0);
    req_stb = 4'b0011;
    @(negedge clk);
    check("wrst_add_input_stb",   32'(add_input_stb),   32'h0);
    check("wrst_add_output_busy", 32'(add_output_busy), 32'h1);
    check("wrst_rsp_stb",         32'(rsp_stb),         32'h0);
    check("wrst_rsp_sum",         rsp_sum,              32'h0);
    check("wrst_req_busy",        32'(req_busy),        32'hF);
    check("wrst_add_a",           add_a,                32'h0);
    check("wrst_add_b",           add_b,                32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    expect_rsp(0, 32'h40000000);
    expect_rsp(1, 32'h40400000);
    send(4'b0011);
    drain();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fp32_add_arbiter
